// File: rtl/fp_pkg.sv
// fp_pkg: shared defaults, FSM states and constants for the sign-magnitude fixed-point divider.
package fp_pkg;
    localparam int N_DEF = 32;
    localparam int Q_DEF = 15;
    localparam int CNT_W = 8;
    localparam logic [63:0] SAT_MAG = '1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift/subtract step of the divider.
module div_step #(
    parameter int W = 31
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_out,
    output logic         q
);
    logic [W:0] sh;
    assign sh = {rem_in, bit_in};
    assign q = sh >= {1'b0, dvs};
    // rem_in < dvs keeps both the difference and the unchanged shift within W bits
    assign rem_out = q ? W'(sh - {1'b0, dvs}) : sh[W-1:0];
endmodule

// File: rtl/divider_fp_32bit.sv
// divider_fp_32bit: sequential restoring divider for sign-magnitude Q-format words.
// Define DIVIDER_FP_ROUND_EN for an extra guard-bit iteration and round-half-up.
module divider_fp_32bit
    import fp_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         dz
);
    localparam int M = N - 1;
`ifdef DIVIDER_FP_ROUND_EN
    localparam int L = N + Q;
`else
    localparam int L = N - 1 + Q;
`endif
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [M-1:0] dvs, rem, rem_n, mag;
    logic [L-1:0] dq, qx;
    logic sgn, qb, sat, dzc;

    div_step #(.W(M)) u_step (
        .rem_in (rem),
        .bit_in (dq[L-1]),
        .dvs    (dvs),
        .rem_out(rem_n),
        .q      (qb)
    );

`ifdef DIVIDER_FP_ROUND_EN
    assign qx = {1'b0, dq[L-1:1]} + L'(dq[0]);
`else
    assign qx = dq;
`endif
    assign dzc = ~|dvs;
    assign sat = |qx[L-1:M];
    assign mag = (dzc | sat) ? SAT_MAG[M-1:0] : qx[M-1:0];
    assign busy = state != IDLE;

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE: state_n = start ? (|in_b[M-1:0] ? CALC : DONE) : IDLE;
            CALC: state_n = cnt == CNT_W'(L - 1) ? DONE : CALC;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            dvs    <= '0;
            rem    <= '0;
            dq     <= '0;
            sgn    <= 1'b0;
            result <= '0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt <= '0;
                    dvs <= in_b[M-1:0];
                    rem <= '0;
                    dq  <= {in_a[M-1:0], {(L-M){1'b0}}};
                    sgn <= in_a[N-1] ^ in_b[N-1];
                    ovf <= 1'b0;
                    dz  <= 1'b0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    rem <= rem_n;
                    dq  <= {dq[L-2:0], qb};
                end
                default: begin
                    done   <= 1'b1;
                    dz     <= dzc;
                    ovf    <= ~dzc & sat;
                    result <= {sgn & |mag, mag};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_fp_32bit.sv
// tb_divider_fp_32bit: directed self-checking bench for divider_fp_32bit.
module tb_divider_fp_32bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] result;
    logic        busy, done, ovf, dz;
    int          passed = 0;
    int          total = 0;
    int          lat;
    int          ndone;
    bit          busy_ok;

`ifdef DIVIDER_FP_ROUND_EN
    localparam int          LAT   = 48;
    localparam logic [31:0] THIRD = 32'h0000_2AAB;
`else
    localparam int          LAT   = 47;
    localparam logic [31:0] THIRD = 32'h0000_2AAA;
`endif

    divider_fp_32bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .result(result),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit pulse,
                       output int l, output bit bok);
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_a  = ~a;
        in_b  = ~b;
        l   = 0;
        bok = 1'b1;
        while (!done && l < 200) begin
            if (!busy) bok = 1'b0;
            start = pulse && l < 40 && (l % 5) == 2;
            @(posedge clk);
            l++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_result", result, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_ovf", {31'b0, ovf}, 32'h0);
        check("rst_dz", {31'b0, dz}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run(32'h0001_8000, 32'h0001_0000, 1'b0, lat, busy_ok);
        check("1p5_result", result, 32'h0000_C000);
        check("1p5_ovf", {31'b0, ovf}, 32'h0);
        check("1p5_dz", {31'b0, dz}, 32'h0);
        check("1p5_latency", lat, LAT);
        check("1p5_busy", {31'b0, busy_ok}, 32'h1);
        @(negedge clk);
        check("1p5_done_pulse", {31'b0, done}, 32'h0);

        run(32'h8000_8000, 32'h0002_0000, 1'b0, lat, busy_ok);
        check("neg_quarter", result, 32'h8000_2000);
        run(32'h8000_0000, 32'h0001_0000, 1'b0, lat, busy_ok);
        check("neg_zero", result, 32'h0000_0000);
        run(32'h8001_8000, 32'h8001_0000, 1'b0, lat, busy_ok);
        check("negneg_pos", result, 32'h0000_C000);

        run(32'h0000_8000, 32'h8000_0000, 1'b0, lat, busy_ok);
        check("dz_result", result, 32'hFFFF_FFFF);
        check("dz_flag", {31'b0, dz}, 32'h1);
        check("dz_ovf", {31'b0, ovf}, 32'h0);
        check("dz_latency", lat, 1);

        run(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, lat, busy_ok);
        check("ovf_result", result, 32'h7FFF_FFFF);
        check("ovf_flag", {31'b0, ovf}, 32'h1);
        check("ovf_latency", lat, LAT);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("busy_start_ignored", ndone, 0);
        check("ovf_held_result", result, 32'h7FFF_FFFF);
        check("ovf_held_flag", {31'b0, ovf}, 32'h1);

        @(negedge clk);
        in_a  = 32'h0001_8000;
        in_b  = 32'h0001_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run(32'h0000_8000, 32'h0000_8000, 1'b0, lat, busy_ok);
        check("after_abort", result, 32'h0000_8000);
        check("after_abort_latency", lat, LAT);

        run(32'h0000_8000, 32'h0001_8000, 1'b0, lat, busy_ok);
        check("third_result", result, THIRD);
        check("third_latency", lat, LAT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/divider_fp_32bit.md
DIVIDER_FP_32BIT -- requirements
Module: divider_fp_32bit

Interface
REQ-001 SHALL have parameter N, default 32: word width; bit N-1 is the sign, bits N-2:0 are the magnitude (sign-magnitude).
REQ-002 SHALL have parameter Q, default 15: fractional bits of the magnitude.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-006 SHALL have port in_a, input, N: dividend, sign-magnitude Q format.
REQ-007 SHALL have port in_b, input, N: divisor, sign-magnitude Q format.
REQ-008 SHALL have port result, output, N: quotient, registered, held until the next accepted start.
REQ-009 SHALL have port busy, output, 1: high while not in IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when result is valid.
REQ-011 SHALL have port ovf, output, 1: quotient saturated; valid with done, held with result.
REQ-012 SHALL have port dz, output, 1: divisor magnitude zero; valid with done, held with result.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE.
REQ-014 IDLE with start=1 SHALL latch the operand magnitudes and the sign (in_a[N-1] XOR in_b[N-1]) and clear ovf and dz.
- Divisor magnitude zero: next state DONE.
- Otherwise: next state CALC with iteration count L = N-1+Q.
REQ-015 CALC SHALL perform one restoring shift/subtract step per cycle on the dividend magnitude extended by Q zero LSBs, producing one quotient bit MSB-first, and SHALL move to DONE after L cycles.
REQ-016 DONE SHALL assert done for exactly one cycle, update result, ovf and dz, and return to IDLE.
REQ-017 Latency SHALL be as follows, where edge 0 is the edge that samples start:
- Normal: done high in the cycle after edge L+1 (47 edges for the defaults).
- Divide-by-zero: done high after edge 1.
REQ-018 Result magnitude SHALL equal floor((|a| << Q) / |b|), truncated.
REQ-019 If any quotient bit above bit N-2 is set, the magnitude SHALL be saturated to all ones and ovf set to 1.
REQ-020 On divide-by-zero, the magnitude SHALL be all ones, the sign SHALL be the XOR of the operand signs, and dz SHALL be 1.
REQ-021 A zero magnitude result SHALL force the sign bit to 0 (no negative zero).
REQ-022 start while busy SHALL be ignored; in_a and in_b SHALL be don't-care after acceptance.
REQ-023 start asserted in the DONE cycle SHALL be ignored; start is accepted in the following IDLE cycle.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE and result=0, busy=0, done=0, ovf=0, dz=0, clearing the counter and datapath registers.
REQ-025 Reset mid-CALC SHALL abort the operation with no done pulse; the next start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro DIVIDER_FP_ROUND_EN, when defined:
- Adds one CALC iteration (L = N+Q) for a guard bit.
- Rounds half-up on the magnitude.
- Rounding carry past bit N-2 saturates the magnitude and sets ovf.
- Normal latency increases by 1.
REQ-027 Without DIVIDER_FP_ROUND_EN, the block SHALL truncate per REQ-018 and L = N-1+Q.

Structure
REQ-028 Shared package fp_pkg SHALL hold:
- N and Q defaults.
- The state enum {IDLE, CALC, DONE}.
- The saturation magnitude constant.
- The iteration-count width.
REQ-029 A single sub-module div_step (one combinational restore/subtract step: remainder in and out, quotient bit out) SHALL be instantiated once inside the CALC datapath.

Verification
REQ-030 in_a=0x00018000, in_b=0x00010000, start pulse -> result=0x0000C000, ovf=0, dz=0; busy high until done; done after edge 47.
REQ-031 in_a=0x80008000, in_b=0x00020000 -> result=0x80002000; in_a=0x80000000, in_b=0x00010000 -> result=0x00000000.
REQ-032 in_b=0x80000000, in_a=0x00008000 -> dz=1, result=0xFFFFFFFF, done after edge 1.
REQ-033 in_a=0x7FFFFFFF, in_b=0x00000001 -> ovf=1, result=0x7FFFFFFF; start pulses during busy -> no second done.
REQ-034 rst asserted at edge 20 of CALC -> busy, done and result all 0 immediately; then 0x00008000/0x00008000 -> result=0x00008000.
REQ-035 in_a=0x00008000, in_b=0x00018000 -> result=0x00002AAA without DIVIDER_FP_ROUND_EN; result=0x00002AAB with it, done after edge 48.
